// File: rtl/dijkstra_engine_if.sv
// Port bundle for dijkstra_engine: request handshake, adjacency-table read port and result read port.
// target_id is present only when DIJKSTRA_TARGET_EXIT_EN is defined.
interface dijkstra_engine_if #(
  parameter int ID_W   = 9,
  parameter int DIST_W = 14
);
  logic              start;
  logic [ID_W-1:0]   start_id;
`ifdef DIJKSTRA_TARGET_EXIT_EN
  logic [ID_W-1:0]   target_id;
`endif
  logic [ID_W-1:0]   table_row;
  logic [ID_W-1:0]   table_col;
  logic [DIST_W-1:0] table_data;
  logic [ID_W-1:0]   res_addr;
  logic [DIST_W-1:0] res_distance;
  logic [ID_W-1:0]   res_prev;
  logic              busy;
  logic              done;
  logic              error;

`ifdef DIJKSTRA_TARGET_EXIT_EN
  modport master (
    output start, start_id, target_id, table_data, res_addr,
    input  table_row, table_col, res_distance, res_prev, busy, done, error
  );
  modport slave (
    input  start, start_id, target_id, table_data, res_addr,
    output table_row, table_col, res_distance, res_prev, busy, done, error
  );
`else
  modport master (
    output start, start_id, table_data, res_addr,
    input  table_row, table_col, res_distance, res_prev, busy, done, error
  );
  modport slave (
    input  start, start_id, table_data, res_addr,
    output table_row, table_col, res_distance, res_prev, busy, done, error
  );
`endif
endinterface

// File: rtl/dijkstra_engine.sv
// Sequential single-source shortest-path engine reading an external adjacency table one edge per cycle.
// Optional early exit on reaching a target node is enabled by defining DIJKSTRA_TARGET_EXIT_EN.
module dijkstra_engine #(
  parameter int MAX_NODES = 15,
  parameter int ID_W      = 9,
  parameter int DIST_W    = 14
) (
  input logic              clk,
  input logic              reset,
  dijkstra_engine_if.slave bus
);
  localparam int IDX_W = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
  localparam int CNT_W = ID_W + 1;
  localparam logic [DIST_W-1:0] INF      = {DIST_W{1'b1}};
  localparam logic [DIST_W-1:0] DIST_ZERO = {DIST_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(MAX_NODES - 1);
  localparam logic [CNT_W-1:0]  NODES    = CNT_W'(MAX_NODES);
  localparam logic [ID_W-1:0]   ID_ZERO  = {ID_W{1'b0}};
  localparam logic [IDX_W-1:0]  IDX_ZERO = {IDX_W{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_SELECT = 3'd2,
    S_RELAX  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [DIST_W-1:0]  r_dist [MAX_NODES];
  logic [ID_W-1:0]    r_prev [MAX_NODES];
  logic [MAX_NODES-1:0] r_visited;
  logic [IDX_W-1:0]   r_src, r_u, r_best_id;
  logic [DIST_W-1:0]  r_du, r_best_dist;
  logic               r_found, r_busy, r_done, r_error;
  logic [ID_W-1:0]    r_row, r_col;
  logic               w_busy_nxt, w_done_nxt;
  logic [ID_W-1:0]    w_row_nxt, w_col_nxt;
  logic [IDX_W-1:0]   w_idx, w_v, w_sel_id, w_res_idx;
  logic [DIST_W-1:0]  w_sel_dist;
  logic [DIST_W:0]    w_sum;
  logic               w_start_ok, w_found_cur, w_cand, w_sel_found, w_target_hit, w_relax, w_res_ok;

  assign w_start_ok  = bus.start && (bus.start_id < ID_W'(MAX_NODES));
  assign w_idx       = IDX_W'(r_cnt);
  assign w_v         = IDX_W'(r_cnt - CNT_ONE);
  // Scan candidate: a running minimum restarts at index 0; strict < keeps the lowest index on ties.
  assign w_found_cur = r_found && (r_cnt != CNT_ZERO);
  assign w_cand      = !r_visited[w_idx] && (r_dist[w_idx] != INF) &&
                       (!w_found_cur || (r_dist[w_idx] < r_best_dist));
  assign w_sel_found = w_found_cur || w_cand;
  assign w_sel_id    = w_cand ? w_idx : r_best_id;
  assign w_sel_dist  = w_cand ? r_dist[w_idx] : r_best_dist;
  // Table data lags the column address by one cycle, so count c relaxes node c-1.
  assign w_sum       = {1'b0, r_du} + {1'b0, bus.table_data};
  assign w_relax     = (r_state == S_RELAX) && (r_cnt != CNT_ZERO) && (bus.table_data != INF) &&
                       !r_visited[w_v] && (w_v != r_u) && (w_sum < {1'b0, INF}) &&
                       (w_sum[DIST_W-1:0] < r_dist[w_v]);

`ifdef DIJKSTRA_TARGET_EXIT_EN
  logic [ID_W-1:0] r_target;
  assign w_target_hit = w_sel_found && (ID_W'(w_sel_id) == r_target);
`else
  assign w_target_hit = 1'b0;
`endif

  // State register plus registered handshake and table-address outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_row   <= ID_ZERO;
      r_col   <= ID_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
    end
  end

  // Next-state and phase counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_ONE;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = CNT_ZERO;
        if (bus.start) begin
          w_state_nxt = w_start_ok ? S_INIT : S_DONE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_INIT: begin
        if (r_cnt == LAST) begin
          w_state_nxt = S_SELECT;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_state_nxt = S_INIT;
        end
      end
      S_SELECT: begin
        if (r_cnt == LAST) begin
          w_cnt_nxt   = CNT_ZERO;
          w_state_nxt = (!w_sel_found || w_target_hit) ? S_DONE : S_RELAX;
        end else begin
          w_state_nxt = S_SELECT;
        end
      end
      S_RELAX: begin
        if (r_cnt == NODES) begin
          w_state_nxt = S_SELECT;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_state_nxt = S_RELAX;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the upcoming state; an invalid start reaches DONE without ever raising busy.
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    w_row_nxt  = ID_ZERO;
    w_col_nxt  = ID_ZERO;
    case (w_state_nxt)
      S_INIT, S_SELECT: w_busy_nxt = 1'b1;
      S_RELAX: begin
        w_busy_nxt = 1'b1;
        if (w_cnt_nxt < NODES) begin
          w_row_nxt = (r_state == S_RELAX) ? ID_W'(r_u) : ID_W'(w_sel_id);
          w_col_nxt = ID_W'(w_cnt_nxt);
        end else begin
          w_row_nxt = ID_ZERO;
          w_col_nxt = ID_ZERO;
        end
      end
      S_DONE: begin
        w_done_nxt = 1'b1;
        w_busy_nxt = (r_state != S_IDLE);
      end
      default: w_busy_nxt = 1'b0;
    endcase
  end

  // Distance/predecessor tables, visited set and selection bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_NODES; i++) begin
        r_dist[i] <= INF;
        r_prev[i] <= ID_ZERO;
      end
      r_visited   <= {MAX_NODES{1'b0}};
      r_src       <= IDX_ZERO;
      r_u         <= IDX_ZERO;
      r_best_id   <= IDX_ZERO;
      r_du        <= DIST_ZERO;
      r_best_dist <= DIST_ZERO;
      r_found     <= 1'b0;
      r_error     <= 1'b0;
`ifdef DIJKSTRA_TARGET_EXIT_EN
      r_target    <= ID_ZERO;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_error <= !w_start_ok;
            r_src   <= IDX_W'(bus.start_id);
`ifdef DIJKSTRA_TARGET_EXIT_EN
            r_target <= bus.target_id;
`endif
          end
        end
        S_INIT: begin
          r_dist[w_idx]    <= INF;
          r_prev[w_idx]    <= ID_W'(r_cnt);
          r_visited[w_idx] <= 1'b0;
          if (r_cnt == LAST) begin
            r_dist[r_src] <= DIST_ZERO;
          end
        end
        S_SELECT: begin
          r_found     <= w_sel_found;
          r_best_id   <= w_sel_id;
          r_best_dist <= w_sel_dist;
          if ((r_cnt == LAST) && w_sel_found) begin
            r_visited[w_sel_id] <= 1'b1;
            r_u                 <= w_sel_id;
            r_du                <= w_sel_dist;
          end
        end
        S_RELAX: begin
          if (w_relax) begin
            r_dist[w_v] <= w_sum[DIST_W-1:0];
            r_prev[w_v] <= ID_W'(r_u);
          end
        end
        default: r_found <= r_found;
      endcase
    end
  end

  assign w_res_ok          = bus.res_addr < ID_W'(MAX_NODES);
  assign w_res_idx         = IDX_W'(bus.res_addr);
  assign bus.res_distance  = w_res_ok ? r_dist[w_res_idx] : INF;
  assign bus.res_prev      = w_res_ok ? r_prev[w_res_idx] : ID_ZERO;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.error         = r_error;
  assign bus.table_row     = r_row;
  assign bus.table_col     = r_col;
endmodule

// File: tb/tb_dijkstra_engine.sv
// Directed bench for dijkstra_engine: a 4-node instance against hand-worked graphs and a default 15-node
// instance for the invalid-source path. Adjacency table is modelled as a one-cycle-latency memory.
module tb_dijkstra_engine;
  localparam int N = 4;
  localparam logic [13:0] INF = 14'h3fff;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [13:0] g4 [N][N];

  always #5 clk = ~clk;

  dijkstra_engine_if #(.ID_W(9), .DIST_W(14)) if4 ();
  dijkstra_engine_if #(.ID_W(9), .DIST_W(14)) if15 ();

  dijkstra_engine #(.MAX_NODES(N), .ID_W(9), .DIST_W(14)) u_dut4 (
    .clk(clk), .reset(reset), .bus(if4.slave));
  dijkstra_engine #(.MAX_NODES(15), .ID_W(9), .DIST_W(14)) u_dut15 (
    .clk(clk), .reset(reset), .bus(if15.slave));

  always @(posedge clk) begin
    if ((if4.table_row < 9'd4) && (if4.table_col < 9'd4))
      if4.table_data <= g4[if4.table_row[1:0]][if4.table_col[1:0]];
    else
      if4.table_data <= INF;
    if15.table_data <= INF;
  end

  task automatic clear_graph;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        g4[r][c] = INF;
  endtask

  task automatic run4(input logic [8:0] src, output int cyc);
    logic got;
    got = 1'b0;
    cyc = 0;
    @(negedge clk);
    if4.start = 1'b1;
    if4.start_id = src;
    while (!got && (cyc < 2000)) begin
      @(negedge clk);
      if4.start = 1'b0;
      cyc++;
      got = if4.done;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL run_timeout: done=0 after %0d cycles, expected done=1", cyc);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    if4.start = 1'b1;
    if4.start_id = 9'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (if4.busy !== 1'b0 || if4.done !== 1'b0 || if4.error !== 1'b0 || if4.table_row !== 9'd0 || if4.table_col !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b error=%b row=%0d col=%0d, expected all 0",
               if4.busy, if4.done, if4.error, if4.table_row, if4.table_col);
    end
    for (int i = 0; i <= N; i++) begin
      if4.res_addr = 9'(i);
      #1;
      checks++;
      if (if4.res_distance !== INF || if4.res_prev !== 9'd0) begin
        errors++;
        $display("FAIL reset_node%0d: dist=%0d prev=%0d, expected dist=%0d prev=0", i, if4.res_distance, if4.res_prev, INF);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    if4.start = 1'b0;
    @(negedge clk);
    checks++;
    if (if4.busy !== 1'b0 || if15.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_ignored: busy4=%b busy15=%b, expected 0 0", if4.busy, if15.busy);
    end
  endtask

  task automatic test_chain;
    logic [13:0] ed [N] = '{14'd0, 14'd3, 14'd7, 14'h3fff};
    logic [8:0]  ep [N] = '{9'd0, 9'd0, 9'd1, 9'd3};
    int cyc;
    clear_graph();
    g4[0][1] = 14'd3;
    g4[1][2] = 14'd4;
    g4[0][2] = 14'd10;
    run4(9'd0, cyc);
    checks++;
    if (if4.error !== 1'b0 || if4.busy !== 1'b1) begin
      errors++;
      $display("FAIL chain_done_flags: error=%b busy=%b, expected error=0 busy=1", if4.error, if4.busy);
    end
    @(negedge clk);
    checks++;
    if (if4.done !== 1'b0 || if4.busy !== 1'b0 || if4.table_row !== 9'd0 || if4.table_col !== 9'd0) begin
      errors++;
      $display("FAIL chain_after_done: done=%b busy=%b row=%0d col=%0d, expected all 0",
               if4.done, if4.busy, if4.table_row, if4.table_col);
    end
    for (int i = 0; i < N; i++) begin
      if4.res_addr = 9'(i);
      #1;
      checks++;
      if (if4.res_distance !== ed[i] || if4.res_prev !== ep[i]) begin
        errors++;
        $display("FAIL chain_node%0d: dist=%0d prev=%0d, expected dist=%0d prev=%0d",
                 i, if4.res_distance, if4.res_prev, ed[i], ep[i]);
      end
    end
  endtask

  task automatic test_error;
    @(negedge clk);
    if15.start = 1'b1;
    if15.start_id = 9'd20;
    @(negedge clk);
    if15.start = 1'b0;
    checks++;
    if (if15.done !== 1'b1 || if15.error !== 1'b1 || if15.busy !== 1'b0) begin
      errors++;
      $display("FAIL error15_pulse: done=%b error=%b busy=%b, expected 1 1 0", if15.done, if15.error, if15.busy);
    end
    @(negedge clk);
    if15.res_addr = 9'd0;
    #1;
    checks++;
    if (if15.done !== 1'b0 || if15.error !== 1'b1 || if15.busy !== 1'b0 || if15.res_distance !== INF) begin
      errors++;
      $display("FAIL error15_after: done=%b error=%b busy=%b dist0=%0d, expected 0 1 0 %0d",
               if15.done, if15.error, if15.busy, if15.res_distance, INF);
    end
    if15.res_addr = 9'd20;
    #1;
    checks++;
    if (if15.res_distance !== INF || if15.res_prev !== 9'd0) begin
      errors++;
      $display("FAIL error15_res_range: dist=%0d prev=%0d, expected %0d 0", if15.res_distance, if15.res_prev, INF);
    end
    // Boundary id == MAX_NODES on the 4-node engine must leave the chain results intact.
    @(negedge clk);
    if4.start = 1'b1;
    if4.start_id = 9'd4;
    @(negedge clk);
    if4.start = 1'b0;
    if4.res_addr = 9'd2;
    #1;
    checks++;
    if (if4.done !== 1'b1 || if4.error !== 1'b1 || if4.busy !== 1'b0 || if4.res_distance !== 14'd7 || if4.res_prev !== 9'd1) begin
      errors++;
      $display("FAIL error4_boundary: done=%b error=%b busy=%b dist2=%0d prev2=%0d, expected 1 1 0 7 1",
               if4.done, if4.error, if4.busy, if4.res_distance, if4.res_prev);
    end
  endtask

  task automatic test_no_wrap;
    logic [13:0] ed [N] = '{14'd0, 14'h3ffd, 14'h3fff, 14'h3fff};
    logic [8:0]  ep [N] = '{9'd0, 9'd0, 9'd2, 9'd3};
    int cyc;
    clear_graph();
    g4[0][1] = 14'h3ffd;
    g4[1][2] = 14'd5;
    g4[1][3] = 14'd2;
    run4(9'd0, cyc);
    checks++;
    if (if4.error !== 1'b0) begin
      errors++;
      $display("FAIL error_cleared: error=%b, expected 0", if4.error);
    end
    for (int i = 0; i < N; i++) begin
      if4.res_addr = 9'(i);
      #1;
      checks++;
      if (if4.res_distance !== ed[i] || if4.res_prev !== ep[i]) begin
        errors++;
        $display("FAIL nowrap_node%0d: dist=%0d prev=%0d, expected dist=%0d prev=%0d",
                 i, if4.res_distance, if4.res_prev, ed[i], ep[i]);
      end
    end
  endtask

  task automatic test_tie;
    logic [8:0]  srcs [2] = '{9'd0, 9'd2};
    logic [13:0] ed [2][N] = '{'{14'd0, 14'd2, 14'd1, 14'h3fff}, '{14'h3fff, 14'd1, 14'd0, 14'h3fff}};
    logic [8:0]  ep [2][N] = '{'{9'd0, 9'd0, 9'd0, 9'd3}, '{9'd0, 9'd2, 9'd2, 9'd3}};
    int cyc;
    clear_graph();
    g4[0][1] = 14'd2;
    g4[0][2] = 14'd1;
    g4[2][1] = 14'd1;
    g4[3][0] = 14'd1;
    for (int r = 0; r < 2; r++) begin
      run4(srcs[r], cyc);
      for (int i = 0; i < N; i++) begin
        if4.res_addr = 9'(i);
        #1;
        checks++;
        if (if4.res_distance !== ed[r][i] || if4.res_prev !== ep[r][i]) begin
          errors++;
          $display("FAIL tie_src%0d_node%0d: dist=%0d prev=%0d, expected dist=%0d prev=%0d",
                   srcs[r], i, if4.res_distance, if4.res_prev, ed[r][i], ep[r][i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    clear_graph();
    g4[0][1] = 14'd3;
    g4[1][2] = 14'd4;
    g4[0][2] = 14'd10;
    @(negedge clk);
    if4.start = 1'b1;
    if4.start_id = 9'd0;
    repeat (12) begin
      @(negedge clk);
      if4.start = 1'b0;
    end
    checks++;
    if (if4.busy !== 1'b1 || if4.table_row !== 9'd0 || if4.table_col !== 9'd3) begin
      errors++;
      $display("FAIL relax_addr: busy=%b row=%0d col=%0d, expected 1 0 3", if4.busy, if4.table_row, if4.table_col);
    end
    reset = 1'b1;
    @(negedge clk);
    if4.res_addr = 9'd1;
    #1;
    checks++;
    if (if4.busy !== 1'b0 || if4.done !== 1'b0 || if4.table_col !== 9'd0 || if4.res_distance !== INF || if4.res_prev !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b col=%0d dist1=%0d prev1=%0d, expected 0 0 0 %0d 0",
               if4.busy, if4.done, if4.table_col, if4.res_distance, if4.res_prev, INF);
    end
    reset = 1'b0;
    run4(9'd0, cyc);
    if4.res_addr = 9'd2;
    #1;
    checks++;
    if (if4.res_distance !== 14'd7 || if4.res_prev !== 9'd1) begin
      errors++;
      $display("FAIL reset_mid_rerun: dist2=%0d prev2=%0d, expected 7 1", if4.res_distance, if4.res_prev);
    end
  endtask

  task automatic test_back_to_back;
    int dones = 0;
    int first = 0;
    logic busy_at_done = 1'b0;
    int exp_lat;
    exp_lat = 1 + N + N * (2 * N + 1) + N + 1;
    clear_graph();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (r != c) g4[r][c] = 14'd1;
    @(negedge clk);
    if4.start = 1'b1;
    if4.start_id = 9'd0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if4.start = (n == 5 || n == 20 || n == 40) ? 1'b1 : 1'b0;
      if4.start_id = 9'd3;
      if (if4.done) begin
        dones++;
        if (first == 0) begin
          first = n;
          busy_at_done = if4.busy;
        end
      end
    end
    checks++;
    if (dones != 1 || (first + 1) != exp_lat || busy_at_done !== 1'b1 || if4.busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back: dones=%0d latency=%0d busy_at_done=%b busy_end=%b, expected 1 %0d 1 0",
               dones, first + 1, busy_at_done, if4.busy, exp_lat);
    end
    for (int i = 0; i < N; i++) begin
      if4.res_addr = 9'(i);
      #1;
      checks++;
      if (if4.res_distance !== ((i == 0) ? 14'd0 : 14'd1) || if4.res_prev !== 9'd0) begin
        errors++;
        $display("FAIL full_node%0d: dist=%0d prev=%0d, expected dist=%0d prev=0",
                 i, if4.res_distance, if4.res_prev, (i == 0) ? 0 : 1);
      end
    end
  endtask

`ifdef DIJKSTRA_TARGET_EXIT_EN
  task automatic test_target;
    int cyc;
    clear_graph();
    g4[0][1] = 14'd3;
    g4[1][2] = 14'd4;
    g4[0][2] = 14'd10;
    if4.target_id = 9'd1;
    run4(9'd0, cyc);
    if4.target_id = 9'h1ff;
    if4.res_addr = 9'd1;
    #1;
    checks++;
    if (cyc != 18 || if4.res_distance !== 14'd3 || if4.res_prev !== 9'd0) begin
      errors++;
      $display("FAIL target_exit: cycles=%0d dist1=%0d prev1=%0d, expected 18 3 0", cyc, if4.res_distance, if4.res_prev);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    if4.start = 1'b0;
    if4.start_id = 9'd0;
    if4.res_addr = 9'd0;
    if15.start = 1'b0;
    if15.start_id = 9'd0;
    if15.res_addr = 9'd0;
`ifdef DIJKSTRA_TARGET_EXIT_EN
    if4.target_id = 9'h1ff;
    if15.target_id = 9'h1ff;
`endif
    clear_graph();
    test_reset();
    test_chain();
    test_error();
    test_no_wrap();
    test_tie();
    test_reset_mid();
    test_back_to_back();
`ifdef DIJKSTRA_TARGET_EXIT_EN
    test_target();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dijkstra_engine.md
DIJKSTRA_ENGINE -- requirements
Module: dijkstra_engine

Interface
REQ-001 Parameter MAX_NODES, default 15: number of graph nodes, 2..511.
REQ-002 Parameter ID_W, default 9: node-id width.
REQ-003 Parameter DIST_W, default 14: distance and edge-weight width; INF = all ones.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request; sampled only in IDLE.
REQ-007 start_id  in  ID_W  source node, sampled with start.
REQ-008 table_row, table_col  out  ID_W each  adjacency-table read address.
REQ-009 table_data  in  DIST_W  edge weight (row->col), valid one cycle after address; INF = no edge.
REQ-010 res_addr  in  ID_W  result read index.
REQ-011 res_distance  out  DIST_W  combinational dist[res_addr]; INF if unreached or res_addr >= MAX_NODES.
REQ-012 res_prev  out  ID_W  combinational prev[res_addr]; 0 if res_addr >= MAX_NODES.
REQ-013 busy  out  1  high from the cycle after accepted start until the done cycle, inclusive.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 error  out  1  set with done when start_id >= MAX_NODES; cleared on next accepted start.

Function
REQ-016 States: IDLE, INIT, SELECT, RELAX, DONE.
REQ-017 IDLE: start=1 with start_id < MAX_NODES -> INIT; start_id >= MAX_NODES -> DONE with error=1, results unchanged.
REQ-018 INIT: MAX_NODES cycles; node i gets dist=INF, prev=i, visited=0; then dist[start_id]=0 -> SELECT.
REQ-019 SELECT: MAX_NODES-cycle scan; picks unvisited node with minimum dist != INF, ties to lowest index.
REQ-020 SELECT with no candidate -> DONE; otherwise mark u visited -> RELAX.
REQ-021 RELAX: table_row=u, table_col=0..MAX_NODES-1 on consecutive cycles; MAX_NODES+1 cycles total for read latency.
REQ-022 Relax node v only if table_data != INF, v unvisited, v != u.
REQ-023 Sum dist[u]+w at DIST_W+1 bits; sum >= INF is no improvement (no wrap).
REQ-024 Update dist[v]=sum, prev[v]=u only when sum < dist[v] (strict; equal keeps older path).
REQ-025 After RELAX -> SELECT.
REQ-026 DONE: done=1 for exactly one cycle -> IDLE; results hold until next accepted start.
REQ-027 start asserted while busy is ignored; it is neither queued nor restarts.
REQ-028 table_row/table_col are 0 outside RELAX.
REQ-029 Worst-case latency, start to done: 1 + MAX_NODES + MAX_NODES*(2*MAX_NODES+1) + MAX_NODES + 1 cycles.

Reset
REQ-030 reset forces IDLE in the same edge, including mid-operation; busy=0, done=0, error=0.
REQ-031 On reset: all dist=INF, all prev=0, all visited=0, table_row=table_col=0.
REQ-032 start in the reset cycle is ignored.

Configuration
REQ-033 Macro DIJKSTRA_TARGET_EXIT_EN defined: adds input target_id (ID_W), sampled with start.
REQ-034 With the macro, when SELECT marks u == target_id, go directly to DONE, skipping RELAX; other results are partial.
REQ-035 Without the macro, the target_id port is absent and search always runs to exhaustion.

Verification
REQ-036 MAX_NODES=4, chain 0->1 w3, 1->2 w4, 0->2 w10, start_id=0 -> dist {0,3,7,INF}, prev {0,0,1,3}, done one pulse.
REQ-037 start_id=20, MAX_NODES=15 -> done and error next cycle after IDLE; results unchanged; busy never high.
REQ-038 Edges 0->1 w(INF-2), 1->2 w5 -> dist[2]=INF, prev[2]=2, no wrap.
REQ-039 reset asserted mid-RELAX -> next cycle IDLE, busy=0; a new start runs a correct full search.
REQ-040 start re-pulsed while busy -> ignored; single done; done-cycle count matches REQ-029 for full graph.
REQ-041 With DIJKSTRA_TARGET_EXIT_EN, target_id=1 on REQ-036 graph -> done after second SELECT, dist[1]=3.
